// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU instruction sequencer: opcodes, instruction
// field layout at default widths, strobe classes and the instruction length rule.
package tpu_pkg;

  localparam int ARRAY_DIM_DEF   = 16;
  localparam int DATA_BITS_DEF   = 8;
  localparam int ADDR_BITS_DEF   = 8;
  localparam int OPCODE_BITS_DEF = 4;

  localparam int OPERAND_BITS = ARRAY_DIM_DEF * DATA_BITS_DEF;
  localparam int INST_BITS    = OPCODE_BITS_DEF + 2 * ADDR_BITS_DEF + OPERAND_BITS;

  localparam int OPERAND_TO   = 0;
  localparam int OPERAND_FROM = OPERAND_BITS - 1;
  localparam int ADDRB_TO     = OPERAND_BITS;
  localparam int ADDRB_FROM   = ADDRB_TO + ADDR_BITS_DEF - 1;
  localparam int ADDRA_TO     = ADDRB_FROM + 1;
  localparam int ADDRA_FROM   = ADDRA_TO + ADDR_BITS_DEF - 1;
  localparam int OPCODE_TO    = ADDRA_FROM + 1;
  localparam int OPCODE_FROM  = OPCODE_TO + OPCODE_BITS_DEF - 1;

  localparam logic [3:0] OP_IDLE         = 4'h0;
  localparam logic [3:0] OP_WRITE_DATA   = 4'h1;
  localparam logic [3:0] OP_WRITE_WEIGHT = 4'h2;
  localparam logic [3:0] OP_LOAD_DATA    = 4'h3;
  localparam logic [3:0] OP_LOAD_WEIGHT  = 4'h4;
  localparam logic [3:0] OP_MAT_MUL      = 4'h5;
  localparam logic [3:0] OP_MAT_MUL_ACC  = 4'h6;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_WR_UB,
    CLS_WR_WB,
    CLS_LD_UB,
    CLS_LD_WB,
    CLS_MM,
    CLS_MMACC
  } cls_e;

  // A zero-length burst still performs one read, so it costs two cycles.
  function automatic int unsigned inst_len(input cls_e cls, input int unsigned burst,
                                           input int unsigned mm_cycles);
    case (cls)
      CLS_LD_UB, CLS_LD_WB: inst_len = (burst == 0) ? 2 : burst + 1;
      CLS_MM, CLS_MMACC:    inst_len = mm_cycles;
      default:              inst_len = 1;
    endcase
  endfunction

endpackage

// File: rtl/inst_sequencer_cu_decode.sv
// Combinational opcode decoder: maps an opcode (and burst size) to the strobe
// class, the instruction length minus one, and a legality bit.
module cu_decode
  import tpu_pkg::*;
#(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int CNT_W       = 8,
  parameter int MM_CYCLES   = 32
) (
  input  logic [OPCODE_BITS-1:0] i_opcode,
  input  logic [ADDR_BITS-1:0]   i_burst,
  output logic [CNT_W-1:0]       o_len_m1,
  output cls_e                   o_cls,
  output logic                   o_legal
);

  always_comb begin
    o_cls   = CLS_NONE;
    o_legal = 1'b1;
    case (i_opcode)
      OPCODE_BITS'(OP_IDLE):         o_cls = CLS_NONE;
      OPCODE_BITS'(OP_WRITE_DATA):   o_cls = CLS_WR_UB;
      OPCODE_BITS'(OP_WRITE_WEIGHT): o_cls = CLS_WR_WB;
      OPCODE_BITS'(OP_LOAD_DATA):    o_cls = CLS_LD_UB;
      OPCODE_BITS'(OP_LOAD_WEIGHT):  o_cls = CLS_LD_WB;
      OPCODE_BITS'(OP_MAT_MUL):      o_cls = CLS_MM;
      OPCODE_BITS'(OP_MAT_MUL_ACC):  o_cls = CLS_MMACC;
      default:                       o_legal = 1'b0;
    endcase
    o_len_m1 = CNT_W'(inst_len(o_cls, 32'(i_burst), MM_CYCLES) - 1);
  end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: accepts instructions over valid/ready and replays each
// as a fixed, parameter-derived sequence of memory, FIFO and MMU strobes.
module inst_sequencer
  import tpu_pkg::*;
#(
  parameter int ARRAY_DIM   = 16,
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 8,
  parameter int OPCODE_BITS = 4,
  parameter int MM_CYCLES   = 2 * ARRAY_DIM
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             inst_valid,
  output logic                                             inst_ready,
  input  logic [OPCODE_BITS+2*ADDR_BITS+ARRAY_DIM*DATA_BITS-1:0] instruction,
  output logic                                             read_ub,
  output logic                                             write_ub,
  output logic                                             read_wb,
  output logic                                             write_wb,
  output logic                                             read_acc,
  output logic                                             write_acc,
  output logic                                             data_fifo_en,
  output logic                                             weight_fifo_en,
  output logic                                             mm_en,
  output logic                                             acc_en,
  output logic [ADDR_BITS-1:0]                             addra,
  output logic [ADDR_BITS-1:0]                             addrb,
  output logic [ARRAY_DIM*DATA_BITS-1:0]                   dout,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             flag
);

  localparam int OPND_W   = ARRAY_DIM * DATA_BITS;
  localparam int ADDRB_LO = OPND_W;
  localparam int ADDRA_LO = OPND_W + ADDR_BITS;
  localparam int OPC_LO   = OPND_W + 2 * ADDR_BITS;
  localparam int MM_W     = $clog2(MM_CYCLES);
  localparam int CNT_W    = (ADDR_BITS > MM_W) ? ADDR_BITS : MM_W;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_BITS-1:0]  r_k;
  cls_e                  r_cls;
  logic                  r_rdy_en;
  logic                  r_flag;
  logic [ADDR_BITS-1:0]  r_addra, r_addrb;
  logic [OPND_W-1:0]     r_dout;

  logic [CNT_W-1:0]      w_len_m1;
  cls_e                  w_dec_cls;
  logic                  w_dec_legal;
  logic                  w_accept, w_exec, w_cnt_zero, w_is_ld, w_is_mm;

  cu_decode #(
    .OPCODE_BITS (OPCODE_BITS),
    .ADDR_BITS   (ADDR_BITS),
    .CNT_W       (CNT_W),
    .MM_CYCLES   (MM_CYCLES)
  ) u_decode (
    .i_opcode (instruction[OPC_LO +: OPCODE_BITS]),
    .i_burst  (instruction[0 +: ADDR_BITS]),
    .o_len_m1 (w_len_m1),
    .o_cls    (w_dec_cls),
    .o_legal  (w_dec_legal)
  );

  // r_rdy_en keeps inst_ready low until the first clock edge after reset release.
  assign w_exec     = (r_state == S_EXEC);
  assign w_cnt_zero = (r_cnt == '0);
  assign inst_ready = r_rdy_en & (~w_exec | w_cnt_zero);
  assign w_accept   = inst_valid & inst_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)                w_state_nxt = S_EXEC;
    else if (w_exec && w_cnt_zero) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy_en <= 1'b0;
      r_cnt    <= '0;
      r_k      <= '0;
      r_cls    <= CLS_NONE;
      r_flag   <= 1'b0;
      r_addra  <= '0;
      r_addrb  <= '0;
      r_dout   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_cnt   <= w_len_m1;
        r_k     <= '0;
        r_cls   <= w_dec_cls;
        r_addra <= instruction[ADDRA_LO +: ADDR_BITS];
        r_addrb <= instruction[ADDRB_LO +: ADDR_BITS];
        r_dout  <= instruction[0 +: OPND_W];
        if (!w_dec_legal) r_flag <= 1'b1;
      end else if (w_exec && !w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_k   <= r_k + ADDR_BITS'(1);
      end
    end
  end

  // Burst reads run while cnt!=0; FIFO pushes trail them by one cycle (k!=0).
  assign w_is_ld        = (r_cls == CLS_LD_UB) || (r_cls == CLS_LD_WB);
  assign w_is_mm        = (r_cls == CLS_MM) || (r_cls == CLS_MMACC);
  assign read_ub        = w_exec & (r_cls == CLS_LD_UB) & ~w_cnt_zero;
  assign read_wb        = w_exec & (r_cls == CLS_LD_WB) & ~w_cnt_zero;
  assign data_fifo_en   = w_exec & (r_cls == CLS_LD_UB) & (r_k != '0);
  assign weight_fifo_en = w_exec & (r_cls == CLS_LD_WB) & (r_k != '0);
  assign write_ub       = w_exec & (r_cls == CLS_WR_UB);
  assign write_wb       = w_exec & (r_cls == CLS_WR_WB);
  assign mm_en          = w_exec & w_is_mm;
  assign write_acc      = w_exec & w_is_mm & w_cnt_zero;
  assign read_acc       = w_exec & (r_cls == CLS_MMACC) & (r_cnt == CNT_W'(1));
  assign acc_en         = w_exec & (r_cls == CLS_MMACC) & w_cnt_zero;
  assign addra          = r_addra;
  assign addrb          = w_is_ld ? (r_addrb + r_k) : r_addrb;
  assign dout           = r_dout;
  assign busy           = w_exec;
  assign done           = w_exec & w_cnt_zero;
  assign flag           = r_flag;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: a queue-based per-cycle expectation model, directed
// scenarios with literal expectations, and a randomized valid/opcode phase.
module tb_inst_sequencer;
  import tpu_pkg::*;

  localparam int IW = INST_BITS;
  localparam int B_BUSY = 11, B_DONE = 10, B_RUB = 9, B_WUB = 8, B_RWB = 7, B_WWB = 6;
  localparam int B_RACC = 5, B_WACC = 4, B_DF = 3, B_WF = 2, B_MM = 1, B_ACC = 0;
  localparam int MMC = 2 * ARRAY_DIM_DEF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          inst_valid = 1'b0;
  logic          inst_ready;
  logic [IW-1:0] instruction = '0;
  logic read_ub, write_ub, read_wb, write_wb, read_acc, write_acc;
  logic data_fifo_en, weight_fifo_en, mm_en, acc_en, busy, done, flag;
  logic [7:0]    addra, addrb;
  logic [127:0]  dout;

  inst_sequencer dut (
    .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .read_ub(read_ub), .write_ub(write_ub), .read_wb(read_wb),
    .write_wb(write_wb), .read_acc(read_acc), .write_acc(write_acc),
    .data_fifo_en(data_fifo_en), .weight_fifo_en(weight_fifo_en), .mm_en(mm_en),
    .acc_en(acc_en), .addra(addra), .addrb(addrb), .dout(dout), .busy(busy),
    .done(done), .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]  s;
    logic         ca;
    logic [7:0]   a;
    logic         cb;
    logic [7:0]   b;
    logic         cd;
    logic [127:0] d;
  } rec_t;

  rec_t q[$];
  bit   m_rdy_en = 0;
  bit   m_flag = 0;
  int   m_acc_cnt = 0;
  int   dut_done_cnt = 0;
  int   wub_run = 0, wub_max = 0;
  int   n_checks = 0, n_fail = 0;
  rec_t e_cur;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [127:0] d);
    mk = {op, a, b, d};
  endfunction

  // Expand one accepted instruction into its per-cycle expected outputs.
  task automatic expand(input logic [IW-1:0] ins);
    logic [3:0]   op;
    logic [7:0]   a, b;
    logic [127:0] d;
    int n, len;
    rec_t r;
    op = ins[OPCODE_FROM:OPCODE_TO];
    a  = ins[ADDRA_FROM:ADDRA_TO];
    b  = ins[ADDRB_FROM:ADDRB_TO];
    d  = ins[OPERAND_FROM:OPERAND_TO];
    n  = (d[7:0] == 8'd0) ? 1 : int'(d[7:0]);
    case (op)
      OP_LOAD_DATA, OP_LOAD_WEIGHT: len = n + 1;
      OP_MAT_MUL, OP_MAT_MUL_ACC:   len = MMC;
      OP_IDLE, OP_WRITE_DATA, OP_WRITE_WEIGHT: len = 1;
      default: begin len = 1; m_flag = 1; end
    endcase
    for (int c = 0; c < len; c++) begin
      r = '0;
      r.s[B_BUSY] = 1'b1;
      r.s[B_DONE] = (c == len - 1);
      case (op)
        OP_WRITE_DATA, OP_WRITE_WEIGHT: begin
          r.s[(op == OP_WRITE_DATA) ? B_WUB : B_WWB] = 1'b1;
          r.ca = 1'b1; r.a = a; r.cd = 1'b1; r.d = d;
        end
        OP_LOAD_DATA, OP_LOAD_WEIGHT: begin
          if (c < n) begin
            r.s[(op == OP_LOAD_DATA) ? B_RUB : B_RWB] = 1'b1;
            r.cb = 1'b1; r.b = 8'(int'(b) + c);
          end
          if (c >= 1) r.s[(op == OP_LOAD_DATA) ? B_DF : B_WF] = 1'b1;
        end
        OP_MAT_MUL, OP_MAT_MUL_ACC: begin
          r.s[B_MM] = 1'b1;
          if (c == len - 1) begin r.s[B_WACC] = 1'b1; r.ca = 1'b1; r.a = a; end
          if (op == OP_MAT_MUL_ACC && c == len - 2) begin
            r.s[B_RACC] = 1'b1; r.ca = 1'b1; r.a = a;
          end
          if (op == OP_MAT_MUL_ACC && c == len - 1) r.s[B_ACC] = 1'b1;
        end
        default: ;
      endcase
      q.push_back(r);
    end
  endtask

  always @(negedge reset_n) begin
    q.delete();
    m_flag   = 0;
    m_rdy_en = 0;
  end

  // Model advance: the cycle just finished is retired, an accept appends a new one.
  always @(posedge clk) begin
    if (reset_n) begin
      bit rdy;
      rdy = m_rdy_en && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (inst_valid && rdy) begin
        expand(instruction);
        m_acc_cnt++;
      end
      m_rdy_en = 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      e_cur = (q.size() > 0) ? q[0] : '0;
      check("strobes", {busy, done, read_ub, write_ub, read_wb, write_wb, read_acc,
                        write_acc, data_fifo_en, weight_fifo_en, mm_en, acc_en}, e_cur.s);
      check("inst_ready", inst_ready, m_rdy_en && (q.size() <= 1));
      check("flag", flag, m_flag);
      if (e_cur.ca) check("addra", addra, e_cur.a);
      if (e_cur.cb) check("addrb", addrb, e_cur.b);
      if (e_cur.cd) check("dout", dout, e_cur.d);
      if (done) dut_done_cnt++;
      if (write_ub) wub_run++; else wub_run = 0;
      if (wub_run > wub_max) wub_max = wub_run;
    end
  end

  task automatic issue(input logic [IW-1:0] ins);
    int t = 0;
    inst_valid  = 1'b1;
    instruction = ins;
    while (!inst_ready && t < 500) begin @(negedge clk); t++; end
    check("issue_timeout", (t < 500), 1'b1);
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    inst_valid = 1'b0;
    while ((busy || q.size() != 0) && t < 2000) begin @(negedge clk); t++; end
    check("drain_timeout", (t < 2000), 1'b1);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {inst_ready, busy, done, read_ub, write_ub, read_wb, write_wb, read_acc,
               write_acc, data_fifo_en, weight_fifo_en, mm_en, acc_en, flag}, '0);
    check({nm, "_data"}, {addra, addrb, dout}, '0);
  endtask

  initial begin
    logic [127:0] opnd;
    logic [5:0]   rd, wf, dn;
    logic [31:0]  al;
    int mmcnt, racc_c, wacc_c, accen_c, a0, d0;
    logic [7:0]   wa;

    #3 check_all_zero("reset_init");
    @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", inst_ready, 1'b1);

    // 256 back-to-back WRITE_DATA
    wub_max = 0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) opnd[j*8 +: 8] = 8'(i - j);
      issue(mk(OP_WRITE_DATA, 8'(i), 8'h00, opnd));
    end
    drain();
    check("wub_run_len", wub_max, 256);

    // LOAD_WEIGHT wrapping burst
    issue(mk(OP_LOAD_WEIGHT, 8'h00, 8'hFE, 128'd4));
    inst_valid = 1'b0;
    al = '0;
    for (int c = 0; c < 6; c++) begin
      rd[c] = read_wb; wf[c] = weight_fifo_en; dn[c] = done;
      if (read_wb) al = {al[23:0], addrb};
      @(negedge clk);
    end
    check("lw_read", rd, 6'b001111);
    check("lw_fifo", wf, 6'b011110);
    check("lw_done", dn, 6'b010000);
    check("lw_addrs", al, 32'hFEFF0001);

    // MAT_MUL_ACC timing
    issue(mk(OP_MAT_MUL_ACC, 8'd3, 8'h00, 128'h0));
    inst_valid = 1'b0;
    mmcnt = 0; racc_c = -1; wacc_c = -1; accen_c = -1; wa = '0;
    for (int c = 0; c < 34; c++) begin
      if (mm_en) mmcnt++;
      if (read_acc) racc_c = c;
      if (write_acc) begin wacc_c = c; wa = addra; end
      if (acc_en) accen_c = c;
      @(negedge clk);
    end
    check("mma_mm_cycles", mmcnt, 32);
    check("mma_read_acc_c", racc_c, 30);
    check("mma_write_acc_c", wacc_c, 31);
    check("mma_acc_en_c", accen_c, 31);
    check("mma_addra", wa, 8'd3);

    // Reset mid LOAD_DATA burst
    issue(mk(OP_LOAD_DATA, 8'h00, 8'h40, 128'd10));
    inst_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("ld_mid_burst", read_ub, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", inst_ready, 1'b1);
    issue(mk(OP_WRITE_DATA, 8'h05, 8'h00, 128'h0123456789ABCDEF));
    inst_valid = 1'b0;
    check("wd_after_reset", {write_ub, addra}, {1'b1, 8'h05});
    drain();

    // Illegal opcode then IDLE
    d0 = dut_done_cnt;
    issue(mk(4'hF, 8'h11, 8'h22, 128'h0));
    check("illegal_flag", flag, 1'b1);
    issue(mk(OP_IDLE, 8'h00, 8'h00, 128'h0));
    inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("flag_sticky", flag, 1'b1);
    check("illegal_idle_dones", dut_done_cnt - d0, 2);

    // Randomized valid and opcode mix
    a0 = m_acc_cnt; d0 = dut_done_cnt;
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [3:0] op;
      sel = $urandom_range(0, 9);
      op  = (sel < 7) ? 4'(sel) : 4'($urandom_range(7, 15));
      opnd = {$urandom, $urandom, $urandom, $urandom};
      opnd[7:0] = 8'($urandom_range(0, 6));
      inst_valid  = 1'($urandom_range(0, 1));
      instruction = mk(op, 8'($urandom), 8'($urandom), opnd);
      @(negedge clk);
    end
    drain();
    check("rand_accept_vs_done", dut_done_cnt - d0, m_acc_cnt - a0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
